// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encoding, instruction layout and funct decode shared by the issue unit.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLL,
      ALU_SRL
   } alu_op_e;

   localparam logic [2:0] FUNCT_ADD     = 3'd0;
   localparam logic [2:0] FUNCT_SUB     = 3'd1;
   localparam logic [2:0] FUNCT_AND     = 3'd2;
   localparam logic [2:0] FUNCT_OR      = 3'd3;
   localparam logic [2:0] FUNCT_XOR     = 3'd4;
   localparam logic [2:0] FUNCT_SLL     = 3'd5;
   localparam logic [2:0] FUNCT_SRL     = 3'd6;
   localparam logic [2:0] FUNCT_ILLEGAL = 3'd7;

   typedef struct packed {
      logic [2:0] funct;
      logic       imm_sel;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [2:0] lo;
   } instr_fields_t;

   typedef struct packed {
      logic [9:0] hi;
      logic [5:0] imm6;
   } instr_imm_t;

   // The immediate occupies the rs2 slot plus the three spare low bits.
   typedef union packed {
      instr_fields_t f;
      instr_imm_t    i;
   } instr_t;

   typedef struct packed {
      alu_op_e op;
      logic    illegal;
   } dec_t;

   function automatic dec_t decode_funct(input logic [2:0] funct);
      dec_t d;
      d.illegal = 1'b0;
      case (funct)
         FUNCT_ADD: d.op = ALU_ADD;
         FUNCT_SUB: d.op = ALU_SUB;
         FUNCT_AND: d.op = ALU_AND;
         FUNCT_OR:  d.op = ALU_OR;
         FUNCT_XOR: d.op = ALU_XOR;
         FUNCT_SLL: d.op = ALU_SLL;
         FUNCT_SRL: d.op = ALU_SRL;
         default: begin
            d.op      = ALU_ADD;
            d.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 8-entry register file, two combinational reads, one write, r0 hardwired to zero.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [2:0]       waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [2:0]       raddr_a_i,
   input  logic [2:0]       raddr_b_i,
   output logic [WIDTH-1:0] rdata_a_o,
   output logic [WIDTH-1:0] rdata_b_o
);

   logic [WIDTH-1:0] mem_q [8];

   // Entry 0 is cleared on reset and never written, so it always reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mem_q[i] <= '0;
      end else if (we_i && waddr_i != 3'd0) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: decodes 16-bit ALU instructions, drives the external ALU core from a decode
// stage, writes results back to the register file and streams them out through an output stage.
module alu_issue_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_instr,
   output alu_op_e          alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic [2:0]       res_rd,
   output logic             res_illegal,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] illegal_cnt
);

   logic             d_valid_q, d_valid_d;
   instr_t           d_instr_q, d_instr_d;
   logic             r_valid_q, r_valid_d;
   logic [WIDTH-1:0] r_data_q, r_data_d;
   logic             r_zero_q, r_zero_d;
   logic [2:0]       r_rd_q, r_rd_d;
   logic             r_ill_q, r_ill_d;
   logic [CNT_W-1:0] ret_q, ret_d, ill_q, ill_d;
   logic [WIDTH-1:0] rs1_val, rs2_val, imm_val;
   logic             advance, accept, live;
   dec_t             dec;

   assign dec     = decode_funct(d_instr_q.f.funct);
   assign advance = d_valid_q && (!r_valid_q || res_ready);
   assign in_ready = rst_n && (!d_valid_q || advance);
   assign accept  = in_valid && in_ready;
   assign live    = d_valid_q && !dec.illegal;
   assign imm_val = {{(WIDTH-6){1'b0}}, d_instr_q.i.imm6};

   // Empty or illegal decode slots present a harmless ADD 0,0 to the core.
   assign alu_op = live ? dec.op : ALU_ADD;
   assign alu_a  = live ? rs1_val : '0;
   assign alu_b  = !live ? '0 : d_instr_q.f.imm_sel ? imm_val : rs2_val;

   alu_regfile #(.WIDTH(WIDTH)) u_rf (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (advance && !dec.illegal),
      .waddr_i   (d_instr_q.f.rd),
      .wdata_i   (alu_result),
      .raddr_a_i (d_instr_q.f.rs1),
      .raddr_b_i (d_instr_q.f.rs2),
      .rdata_a_o (rs1_val),
      .rdata_b_o (rs2_val)
   );

   always_comb begin
      d_valid_d = accept || (d_valid_q && !advance);
      d_instr_d = accept ? instr_t'(in_instr) : d_instr_q;
      r_valid_d = advance || (r_valid_q && !res_ready);
      r_data_d  = !advance ? r_data_q : dec.illegal ? '0 : alu_result;
      r_zero_d  = !advance ? r_zero_q : !dec.illegal && alu_zero;
      r_rd_d    = advance ? d_instr_q.f.rd : r_rd_q;
      r_ill_d   = advance ? dec.illegal : r_ill_q;
      ret_d     = (advance && !dec.illegal && ~&ret_q) ? ret_q + 1'b1 : ret_q;
      ill_d     = (advance && dec.illegal && ~&ill_q) ? ill_q + 1'b1 : ill_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_valid_q <= 1'b0;
         d_instr_q <= '0;
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
         r_zero_q  <= 1'b0;
         r_rd_q    <= '0;
         r_ill_q   <= 1'b0;
         ret_q     <= '0;
         ill_q     <= '0;
      end else begin
         d_valid_q <= d_valid_d;
         d_instr_q <= d_instr_d;
         r_valid_q <= r_valid_d;
         r_data_q  <= r_data_d;
         r_zero_q  <= r_zero_d;
         r_rd_q    <= r_rd_d;
         r_ill_q   <= r_ill_d;
         ret_q     <= ret_d;
         ill_q     <= ill_d;
      end
   end

   assign res_valid   = r_valid_q;
   assign res_data    = r_data_q;
   assign res_zero    = r_zero_q;
   assign res_rd      = r_rd_q;
   assign res_illegal = r_ill_q;
   assign retired_cnt = ret_q;
   assign illegal_cnt = ill_q;

endmodule
